// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache tag/valid table scan engine:
//   ADDR_W / DEPTH  - table geometry (DEPTH is always 2**ADDR_W)
//   OP_*            - operation encodings carried on the 2-bit op port
//   scan_state_t    - sequencing FSM states
package cache_pkg;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [1:0] OP_FIND  = 2'b00;
    localparam logic [1:0] OP_FLUSH = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } scan_state_t;

endpackage

// File: rtl/cache_table_scan.sv
// cache_table_scan
// Walks the 1-bit cache tag/valid table from index 0 upward on a single
// start request and performs FIND (first entry equal to target), FLUSH
// (write target everywhere) or COUNT (number of entries equal to target).
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start, op, target   request; sampled only while idle
//   busy                high while scanning
//   done                one-cycle completion pulse
//   found, result       operation outcome, held until the next accepted start
//   tbl_we/addr/wd      drive the table write-enable, index and write data
//   tbl_rd              table read data (combinational read of tbl_addr)
//
// tbl_rd feeds only next-state logic; every output is decoded from
// registered state, so there is no combinational path from tbl_rd out.
module cache_table_scan #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DEPTH  = cache_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W:0]   result,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic              tbl_wd,
    input  logic              tbl_rd
);
    import cache_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_WIDE = (ADDR_W + 1)'(DEPTH);

    scan_state_t       state_reg,  state_next;
    logic [ADDR_W-1:0] ptr_reg,    ptr_next;
    logic [ADDR_W:0]   cnt_reg,    cnt_next;
    logic [1:0]        op_reg,     op_next;
    logic              target_reg, target_next;
    logic              found_reg,  found_next;
    logic [ADDR_W:0]   result_reg, result_next;

    logic              match;
    logic              last;
    logic [ADDR_W:0]   count_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            op_reg     <= OP_FIND;
            target_reg <= 1'b0;
            found_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            target_reg <= target_next;
            found_reg  <= found_next;
            result_reg <= result_next;
        end
    end

    assign match     = (tbl_rd == target_reg);
    assign last      = (ptr_reg == LAST_IDX);
    // Count including the entry under the pointer this cycle, so the final
    // entry is already included when the scan ends.
    assign count_sum = cnt_reg + {{ADDR_W{1'b0}}, match};

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        target_next = target_reg;
        found_next  = found_reg;
        result_next = result_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    op_next     = op;
                    target_next = target;
                    ptr_next    = '0;
                    cnt_next    = '0;
                    found_next  = 1'b0;
                    result_next = '0;
                    // Reserved op completes immediately with a cleared result.
                    state_next  = (op == OP_RSVD) ? ST_DONE : ST_SCAN;
                end
            end

            ST_SCAN: begin
                case (op_reg)
                    OP_FIND: begin
                        if (match) begin
                            found_next  = 1'b1;
                            result_next = {1'b0, ptr_reg};
                            state_next  = ST_DONE;
                        end else if (last) begin
                            found_next  = 1'b0;
                            result_next = '0;
                            state_next  = ST_DONE;
                        end else begin
                            ptr_next = ptr_reg + 1'b1;
                        end
                    end
                    OP_FLUSH: begin
                        if (last) begin
                            found_next  = 1'b1;
                            result_next = DEPTH_WIDE;
                            state_next  = ST_DONE;
                        end else begin
                            ptr_next = ptr_reg + 1'b1;
                        end
                    end
                    OP_COUNT: begin
                        cnt_next = count_sum;
                        if (last) begin
                            found_next  = (count_sum != '0);
                            result_next = count_sum;
                            state_next  = ST_DONE;
                        end else begin
                            ptr_next = ptr_reg + 1'b1;
                        end
                    end
                    default: state_next = ST_DONE;
                endcase
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; reset forces tbl_we low at once.
    assign busy     = (state_reg == ST_SCAN);
    assign done     = (state_reg == ST_DONE);
    assign found    = found_reg;
    assign result   = result_reg;
    assign tbl_we   = busy && (op_reg == OP_FLUSH);
    assign tbl_addr = busy ? ptr_reg : '0;
    assign tbl_wd   = tbl_we ? target_reg : 1'b0;

endmodule

// File: tb/tb_cache_table_scan.sv
module tb_cache_table_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic       target;
    logic       busy;
    logic       done;
    logic       found;
    logic [8:0] result;
    logic       tbl_we;
    logic [7:0] tbl_addr;
    logic       tbl_wd;
    logic       tbl_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_table_scan dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .target   (target),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .result   (result),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_wd   (tbl_wd),
        .tbl_rd   (tbl_rd)
    );

    // Table model: 256 x 1, combinational read, write on rising edge.
    // The bench preloads it through clear/load requests on the same edge.
    logic       mem [0:255];
    logic       clr_en = 1'b0;
    logic       clr_val = 1'b0;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic       ld_val = 1'b0;

    assign tbl_rd = mem[tbl_addr];

    always @(posedge clk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_wd;
        end else if (clr_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= clr_val;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_val;
        end
    end

    task automatic fill_table(input logic v);
        @(negedge clk);
        clr_val = v;
        clr_en  = 1'b1;
        @(negedge clk);
        clr_en  = 1'b0;
    endtask

    task automatic set_entry(input int a, input logic v);
        @(negedge clk);
        ld_addr = 8'(a);
        ld_val  = v;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issues one request and waits (bounded) for the scan to finish.
    // Returns SCAN cycle count, write count, whether write addresses ran
    // 0,1,2,..., and done level on the first and following non-busy cycle.
    task automatic run_op(input logic [1:0] o, input logic t,
                          output int scans, output int writes, output bit addr_seq_ok,
                          output logic done_now, output logic done_next);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        target = t;
        @(negedge clk);
        start  = 1'b0;
        scans = 0;
        writes = 0;
        addr_seq_ok = 1'b1;
        while (busy && scans < 400) begin
            if (tbl_we) begin
                if (int'(tbl_addr) != scans) addr_seq_ok = 1'b0;
                writes++;
            end
            scans++;
            @(negedge clk);
        end
        done_now = done;
        @(negedge clk);
        done_next = done;
        $display("txn op=%0d target=%0d scans=%0d writes=%0d found=%0d result=%0d",
                 o, t, scans, writes, found, result);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; target = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got %0d exp 0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got %0d exp 0", done); end
        checks++; if (found !== 1'b0)    begin failures++; $display("FAIL reset_found got %0d exp 0", found); end
        checks++; if (result !== 9'd0)   begin failures++; $display("FAIL reset_result got %0d exp 0", result); end
        checks++; if (tbl_we !== 1'b0)   begin failures++; $display("FAIL reset_we got %0d exp 0", tbl_we); end
        checks++; if (tbl_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got %0d exp 0", tbl_addr); end
        checks++; if (tbl_wd !== 1'b0)   begin failures++; $display("FAIL reset_wd got %0d exp 0", tbl_wd); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_flush_count;
        int s, w; bit aok; logic d0, d1;
        fill_table(1'b1);
        run_op(2'b01, 1'b0, s, w, aok, d0, d1);
        checks++; if (s != 256)       begin failures++; $display("FAIL flush_scans got %0d exp 256", s); end
        checks++; if (w != 256)       begin failures++; $display("FAIL flush_writes got %0d exp 256", w); end
        checks++; if (aok !== 1'b1)   begin failures++; $display("FAIL flush_addr_seq got %0d exp 1", aok); end
        checks++; if (d0 !== 1'b1)    begin failures++; $display("FAIL flush_done got %0d exp 1", d0); end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL flush_found got %0d exp 1", found); end
        checks++; if (result !== 9'd256) begin failures++; $display("FAIL flush_result got %0d exp 256", result); end
        run_op(2'b10, 1'b0, s, w, aok, d0, d1);
        checks++; if (result !== 9'd256) begin failures++; $display("FAIL count0_all_result got %0d exp 256", result); end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL count0_all_found got %0d exp 1", found); end
        checks++; if (w != 0)         begin failures++; $display("FAIL count_writes got %0d exp 0", w); end
    endtask

    task automatic test_find;
        int s, w; bit aok; logic d0, d1;
        fill_table(1'b0);
        set_entry(5, 1'b1);
        set_entry(200, 1'b1);
        run_op(2'b00, 1'b1, s, w, aok, d0, d1);
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL find5_found got %0d exp 1", found); end
        checks++; if (result !== 9'd5) begin failures++; $display("FAIL find5_result got %0d exp 5", result); end
        checks++; if (s != 6)         begin failures++; $display("FAIL find5_scans got %0d exp 6", s); end
        checks++; if (d0 !== 1'b1)    begin failures++; $display("FAIL find5_done got %0d exp 1", d0); end
        checks++; if (d1 !== 1'b0)    begin failures++; $display("FAIL find5_done_width got %0d exp 0", d1); end
        checks++; if (result !== 9'd5) begin failures++; $display("FAIL find5_hold got %0d exp 5", result); end

        fill_table(1'b0);
        run_op(2'b00, 1'b1, s, w, aok, d0, d1);
        checks++; if (found !== 1'b0) begin failures++; $display("FAIL findmiss_found got %0d exp 0", found); end
        checks++; if (result !== 9'd0) begin failures++; $display("FAIL findmiss_result got %0d exp 0", result); end
        checks++; if (s != 256)       begin failures++; $display("FAIL findmiss_scans got %0d exp 256", s); end

        set_entry(255, 1'b1);
        run_op(2'b00, 1'b1, s, w, aok, d0, d1);
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL find255_found got %0d exp 1", found); end
        checks++; if (result !== 9'd255) begin failures++; $display("FAIL find255_result got %0d exp 255", result); end
        checks++; if (s != 256)       begin failures++; $display("FAIL find255_scans got %0d exp 256", s); end
    endtask

    task automatic test_count;
        int s, w; bit aok; logic d0, d1;
        fill_table(1'b0);
        set_entry(0, 1'b1);
        set_entry(127, 1'b1);
        set_entry(255, 1'b1);
        run_op(2'b10, 1'b1, s, w, aok, d0, d1);
        checks++; if (result !== 9'd3) begin failures++; $display("FAIL count1_result got %0d exp 3", result); end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL count1_found got %0d exp 1", found); end
        checks++; if (s != 256)       begin failures++; $display("FAIL count1_scans got %0d exp 256", s); end
        run_op(2'b10, 1'b0, s, w, aok, d0, d1);
        checks++; if (result !== 9'd253) begin failures++; $display("FAIL count0_result got %0d exp 253", result); end
        fill_table(1'b0);
        run_op(2'b10, 1'b1, s, w, aok, d0, d1);
        checks++; if (result !== 9'd0) begin failures++; $display("FAIL count_zero_result got %0d exp 0", result); end
        checks++; if (found !== 1'b0) begin failures++; $display("FAIL count_zero_found got %0d exp 0", found); end
    endtask

    task automatic test_ignored_start;
        int s;
        fill_table(1'b0);
        set_entry(50, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 2'b00; target = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = 0;
        while (busy && s < 400) begin
            if (s == 10) begin start = 1'b1; op = 2'b10; target = 1'b0; end
            else start = 1'b0;
            s++;
            @(negedge clk);
        end
        start = 1'b0;
        $display("txn find-with-ignored-start scans=%0d found=%0d result=%0d", s, found, result);
        checks++; if (s != 51)         begin failures++; $display("FAIL ignore_scans got %0d exp 51", s); end
        checks++; if (result !== 9'd50) begin failures++; $display("FAIL ignore_result got %0d exp 50", result); end
        checks++; if (found !== 1'b1)  begin failures++; $display("FAIL ignore_found got %0d exp 1", found); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL ignore_not_queued got %0d exp 0", busy); end
    endtask

    task automatic test_reserved;
        int s, w; bit aok; logic d0, d1;
        // Previous result is nonzero, so a cleared result is observable.
        run_op(2'b11, 1'b1, s, w, aok, d0, d1);
        checks++; if (s != 0)          begin failures++; $display("FAIL rsvd_scans got %0d exp 0", s); end
        checks++; if (d0 !== 1'b1)     begin failures++; $display("FAIL rsvd_done got %0d exp 1", d0); end
        checks++; if (found !== 1'b0)  begin failures++; $display("FAIL rsvd_found got %0d exp 0", found); end
        checks++; if (result !== 9'd0) begin failures++; $display("FAIL rsvd_result got %0d exp 0", result); end
        checks++; if (w != 0)          begin failures++; $display("FAIL rsvd_writes got %0d exp 0", w); end
        checks++; if (mem[50] !== 1'b1) begin failures++; $display("FAIL rsvd_table got %0d exp 1", mem[50]); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] bpat, dpat;
        fill_table(1'b0);
        set_entry(0, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 2'b00; target = 1'b1;
        // Expected per-cycle state: SCAN, DONE, IDLE (re-accept), SCAN.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bpat[3-i] = busy;
            dpat[3-i] = done;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        $display("txn back-to-back busy=%b done=%b", bpat, dpat);
        checks++; if (bpat !== 4'b1001) begin failures++; $display("FAIL b2b_busy got %b exp 1001", bpat); end
        checks++; if (dpat !== 4'b0100) begin failures++; $display("FAIL b2b_done got %b exp 0100", dpat); end
    endtask

    task automatic test_reset_mid_flush;
        int s, ones;
        fill_table(1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b01; target = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = 0;
        while (!(busy && tbl_addr == 8'd100) && s < 400) begin
            s++;
            @(negedge clk);
        end
        checks++; if (s != 100) begin failures++; $display("FAIL midrst_reach got %0d exp 100", s); end
        rst_n = 1'b0;
        #1;
        checks++; if (tbl_we !== 1'b0) begin failures++; $display("FAIL midrst_we got %0d exp 0", tbl_we); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL midrst_busy got %0d exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL midrst_no_resume got %0d exp 0", busy); end
        ones = 0;
        for (int i = 0; i < 256; i++) if (mem[i] === 1'b1) ones++;
        $display("txn reset-mid-flush ones=%0d", ones);
        checks++; if (ones != 100)      begin failures++; $display("FAIL midrst_ones got %0d exp 100", ones); end
        checks++; if (mem[99] !== 1'b1) begin failures++; $display("FAIL midrst_e99 got %0d exp 1", mem[99]); end
        checks++; if (mem[100] !== 1'b0) begin failures++; $display("FAIL midrst_e100 got %0d exp 0", mem[100]); end
    endtask

    initial begin
        test_reset;
        test_flush_count;
        test_find;
        test_count;
        test_ignored_start;
        test_reserved;
        test_back_to_back;
        test_reset_mid_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
